// File: rtl/imm_decode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : imm_decode_ctrl_if
// Purpose  : Bundles the fetch-side handshake, the extender configuration
//            path, the execute-side entry and the stall counter of the
//            immediate decode controller.
// Modports :
//   slave  - controller view (receives instructions, drives entry/extender)
//   master - environment view (fetch, extender and execute stage)
// Signals  :
//   flush, in_valid, in_instr, in_pc, ext_out, out_ready  (env -> ctrl)
//   in_ready, ext_imm_src, ext_inp, out_valid, out_instr, out_pc,
//   out_imm, out_has_imm, out_illegal, stall_cnt          (ctrl -> env)
// Revision : 1.0 - initial release
// ============================================================================
interface imm_decode_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_instr;
  logic [XLEN-1:0]  in_pc;
  logic [1:0]       ext_imm_src;
  logic [24:0]      ext_inp;
  logic [XLEN-1:0]  ext_out;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_instr;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_imm;
  logic             out_has_imm;
  logic             out_illegal;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, ext_out, out_ready,
    output in_ready, ext_imm_src, ext_inp, out_valid, out_instr, out_pc,
           out_imm, out_has_imm, out_illegal, stall_cnt
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, ext_out, out_ready,
    input  in_ready, ext_imm_src, ext_inp, out_valid, out_instr, out_pc,
           out_imm, out_has_imm, out_illegal, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/imm_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imm_decode_ctrl
// Purpose  : Decode-stage controller for an external combinational immediate
//            extender. Accepts instructions over valid/ready, decodes the
//            opcode into the extender's ImmSrc, and registers instruction,
//            PC and extended immediate into a one-entry decode->execute slot.
// Ports    :
//   clk    - clock, rising edge
//   reset  - asynchronous, active-high reset
//   bus    - imm_decode_ctrl_if.slave (handshakes, extender path, entry,
//            stall counter)
// Config   : IMM_ITYPE_EN - when defined, I-type ALU (0010011) and jalr
//            (1100111) decode as ImmSrc 00 with an immediate; otherwise
//            both are treated as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module imm_decode_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  imm_decode_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           state_q;
  logic [XLEN-1:0]  instr_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  imm_q;
  logic             has_imm_q;
  logic             illegal_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  logic [6:0]       opcode;
  logic [1:0]       imm_src;
  logic             has_imm;
  logic             illegal;
  logic             in_ready;
  logic             accept;
  logic             stall;

  assign opcode = bus.in_instr[6:0];

  // Opcode decode; the extender is configured from whatever is on the
  // fetch bus each cycle, independent of in_valid.
  always_comb begin
    imm_src = 2'b00;
    has_imm = 1'b0;
    illegal = 1'b0;
    case (opcode)
      7'b0000011: begin imm_src = 2'b00; has_imm = 1'b1; end
      7'b0100011: begin imm_src = 2'b01; has_imm = 1'b1; end
      7'b1100011: begin imm_src = 2'b10; has_imm = 1'b1; end
      7'b1101111: begin imm_src = 2'b11; has_imm = 1'b1; end
      7'b0110011: begin imm_src = 2'b00; has_imm = 1'b0; end
`ifdef IMM_ITYPE_EN
      7'b0010011,
      7'b1100111: begin imm_src = 2'b00; has_imm = 1'b1; end
`endif
      default:    begin illegal = 1'b1; end
    endcase
  end

  // Flush blocks acceptance outright; otherwise the slot can take a new
  // entry when empty or when the current one drains this same cycle.
  assign in_ready = !bus.flush && ((state_q == S_EMPTY) || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign stall    = (state_q == S_FULL) && !bus.out_ready && !bus.flush;

  // Saturating stall counter, never cleared except by reset.
  assign stall_cnt_d = (stall && (stall_cnt_q != {CNT_W{1'b1}}))
                       ? stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}
                       : stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      instr_q     <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      has_imm_q   <= 1'b0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (bus.flush) begin
        state_q <= S_EMPTY;
      end else if (accept) begin
        // Covers both EMPTY->FULL and drain+accept pass-through.
        state_q   <= S_FULL;
        instr_q   <= bus.in_instr;
        pc_q      <= bus.in_pc;
        imm_q     <= has_imm ? bus.ext_out : '0;
        has_imm_q <= has_imm;
        illegal_q <= illegal;
      end else if ((state_q == S_FULL) && bus.out_ready) begin
        state_q <= S_EMPTY;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.ext_imm_src = imm_src;
  assign bus.ext_inp     = bus.in_instr[31:7];
  assign bus.out_valid   = (state_q == S_FULL);
  assign bus.out_instr   = instr_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_has_imm = has_imm_q;
  assign bus.out_illegal = illegal_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_decode_ctrl
// Purpose  : Self-checking bench for imm_decode_ctrl. Supplies a behavioural
//            immediate extender and compares the controller against a
//            reference model of the handshake, decode and stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_decode_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  imm_decode_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  imm_decode_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External extender: rebuilds the instruction from inp and formats the
  // immediate according to ImmSrc.
  logic [31:0] ext_i;
  always_comb begin
    ext_i = {bus.ext_inp, 7'b0};
    case (bus.ext_imm_src)
      2'b00:   bus.ext_out = {{20{ext_i[31]}}, ext_i[31:20]};
      2'b01:   bus.ext_out = {{20{ext_i[31]}}, ext_i[31:25], ext_i[11:7]};
      2'b10:   bus.ext_out = {{19{ext_i[31]}}, ext_i[31], ext_i[7], ext_i[30:25], ext_i[11:8], 1'b0};
      default: bus.ext_out = {{11{ext_i[31]}}, ext_i[31], ext_i[19:12], ext_i[20], ext_i[30:21], 1'b0};
    endcase
  end

  // ---------------- reference model ----------------
  bit          m_valid;
  logic [31:0] m_instr, m_pc, m_imm;
  bit          m_has, m_ill;
  int          m_cnt;

  // src_known is 0 where the ImmSrc value carries no meaning (illegal).
  function automatic void ref_dec(input logic [31:0] ins, output logic [1:0] src,
                                  output bit has, output bit ill, output bit src_known);
    src = 2'b00; has = 1'b0; ill = 1'b0; src_known = 1'b1;
    if (ins[6:0] == 7'h03)      begin src = 2'd0; has = 1'b1; end
    else if (ins[6:0] == 7'h23) begin src = 2'd1; has = 1'b1; end
    else if (ins[6:0] == 7'h63) begin src = 2'd2; has = 1'b1; end
    else if (ins[6:0] == 7'h6F) begin src = 2'd3; has = 1'b1; end
    else if (ins[6:0] == 7'h33) begin src = 2'd0; end
`ifdef IMM_ITYPE_EN
    else if (ins[6:0] == 7'h13 || ins[6:0] == 7'h67) begin src = 2'd0; has = 1'b1; end
`endif
    else begin ill = 1'b1; src_known = 1'b0; end
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [1:0] src; bit has, ill, k;
    logic [11:0] i12; logic [12:0] b13; logic [20:0] j21;
    ref_dec(ins, src, has, ill, k);
    if (!has) return 32'h0;
    case (src)
      2'd0: begin i12 = ins[31:20]; return 32'($signed(i12)); end
      2'd1: begin i12 = {ins[31:25], ins[11:7]}; return 32'($signed(i12)); end
      2'd2: begin b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; return 32'($signed(b13)); end
      default: begin j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; return 32'($signed(j21)); end
    endcase
  endfunction

  function automatic bit m_ready();
    return !bus.flush && (!m_valid || bus.out_ready);
  endfunction

  task automatic drive(input bit fl, input bit v, input logic [31:0] ins,
                       input logic [31:0] pc, input bit ordy);
    bus.flush     = fl;
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    #1;
  endtask

  // Advance the model with the inputs seen at the coming edge, then the DUT.
  task automatic tick();
    logic [1:0] s; bit h, il, k, acc;
    if (reset) begin
      m_valid = 0; m_instr = 0; m_pc = 0; m_imm = 0; m_has = 0; m_ill = 0; m_cnt = 0;
    end else begin
      acc = bus.in_valid && m_ready();
      if (m_valid && !bus.out_ready && !bus.flush && m_cnt < CMAX) m_cnt++;
      if (bus.flush) m_valid = 0;
      else if (acc) begin
        ref_dec(bus.in_instr, s, h, il, k);
        m_valid = 1; m_instr = bus.in_instr; m_pc = bus.in_pc;
        m_has = h; m_ill = il; m_imm = h ? ref_imm(bus.in_instr) : 32'h0;
      end else if (bus.out_ready) m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 32'h0, 32'h0, 1);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_has_imm, bus.out_illegal} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {bus.out_valid, bus.out_has_imm, bus.out_illegal});
    end
    checks++;
    if ({bus.out_instr, bus.out_pc, bus.out_imm} !== 96'h0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", bus.out_instr, bus.out_pc, bus.out_imm);
    end
    checks++;
    if (bus.stall_cnt !== 4'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.stall_cnt);
    end
  endtask

  task automatic test_decode();
    logic [31:0] t_ins[7]  = '{32'h00412083, 32'hFE112E23, 32'hFE000CE3, 32'h002081B3,
                               32'h0000007F, 32'h00500093, 32'h0080006F};
    logic [1:0]  t_src[7]  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd3};
    bit          t_chk[7]  = '{1, 1, 1, 1, 0, 0, 1};
    logic [31:0] t_imm[7]  = '{32'h4, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h0, 32'h0, 32'h0, 32'h8};
    bit          t_has[7]  = '{1, 1, 1, 0, 0, 0, 1};
    bit          t_ill[7]  = '{0, 0, 0, 0, 1, 1, 0};
`ifdef IMM_ITYPE_EN
    t_chk[5] = 1; t_imm[5] = 32'h5; t_has[5] = 1; t_ill[5] = 0;
`endif
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, t_ins[i], 32'h1000 + 32'(i * 4), 1);
      checks++;
      if (bus.ext_inp !== t_ins[i][31:7]) begin
        failures++; $display("FAIL dec_inp[%0d] got=%h exp=%h", i, bus.ext_inp, t_ins[i][31:7]);
      end
      if (t_chk[i]) begin
        checks++;
        if (bus.ext_imm_src !== t_src[i]) begin
          failures++; $display("FAIL dec_src[%0d] got=%0d exp=%0d", i, bus.ext_imm_src, t_src[i]);
        end
      end
      tick();
      checks++;
      if ({bus.out_valid, bus.out_instr, bus.out_pc, bus.out_imm, bus.out_has_imm, bus.out_illegal} !==
          {1'b1, t_ins[i], 32'h1000 + 32'(i * 4), t_imm[i], t_has[i], t_ill[i]}) begin
        failures++;
        $display("FAIL dec_entry[%0d] got v=%b ins=%h pc=%h imm=%h has=%b ill=%b exp ins=%h imm=%h has=%b ill=%b",
                 i, bus.out_valid, bus.out_instr, bus.out_pc, bus.out_imm, bus.out_has_imm, bus.out_illegal,
                 t_ins[i], t_imm[i], t_has[i], t_ill[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Slot holds jal from the decode test; stall with a new lw waiting.
    for (int k = 1; k <= 3; k++) begin
      drive(0, 1, 32'h00412083, 32'h2000, 0);
      checks++;
      if (bus.in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_ready[%0d] got=%b exp=0", k, bus.in_ready);
      end
      tick();
      checks++;
      if ({bus.out_valid, bus.out_instr, bus.out_imm, bus.stall_cnt} !== {1'b1, 32'h0080006F, 32'h8, 4'(k)}) begin
        failures++; $display("FAIL bp_hold[%0d] got v=%b ins=%h imm=%h cnt=%0d exp ins=0080006f imm=8 cnt=%0d",
                             k, bus.out_valid, bus.out_instr, bus.out_imm, bus.stall_cnt, k);
      end
    end
    drive(0, 1, 32'h00412083, 32'h2000, 1);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready);
    end
    tick();
    checks++;
    if ({bus.out_valid, bus.out_instr, bus.out_pc, bus.out_imm, bus.stall_cnt} !==
        {1'b1, 32'h00412083, 32'h2000, 32'h4, 4'd3}) begin
      failures++; $display("FAIL bp_pass got v=%b ins=%h pc=%h imm=%h cnt=%0d exp ins=00412083 pc=2000 imm=4 cnt=3",
                           bus.out_valid, bus.out_instr, bus.out_pc, bus.out_imm, bus.stall_cnt);
    end
  endtask

  task automatic test_flush();
    drive(1, 1, 32'hFE112E23, 32'h3000, 0);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL flush_ready got=%b exp=0", bus.in_ready);
    end
    tick();
    checks++;
    if ({bus.out_valid, bus.stall_cnt} !== {1'b0, 4'd3}) begin
      failures++; $display("FAIL flush_state got v=%b cnt=%0d exp v=0 cnt=3", bus.out_valid, bus.stall_cnt);
    end
  endtask

  task automatic test_saturation();
    drive(0, 1, 32'h002081B3, 32'h4000, 1);
    tick();
    drive(0, 0, 32'h0, 32'h0, 0);
    repeat (20) tick();
    checks++;
    if ({bus.out_valid, bus.stall_cnt} !== {1'b1, 4'd15}) begin
      failures++; $display("FAIL sat_cnt got v=%b cnt=%0d exp v=1 cnt=15", bus.out_valid, bus.stall_cnt);
    end
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.stall_cnt, bus.out_instr} !== {1'b0, 4'd0, 32'h0}) begin
      failures++; $display("FAIL async_reset got v=%b cnt=%0d ins=%h exp v=0 cnt=0 ins=0",
                           bus.out_valid, bus.stall_cnt, bus.out_instr);
    end
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_random();
    logic [6:0] ops[9] = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h33, 7'h13, 7'h67, 7'h7F, 7'h00};
    logic [31:0] ins; logic [1:0] s; bit h, il, k;
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 8)];
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), ins, $urandom, ($urandom_range(0, 2) != 0));
      ref_dec(ins, s, h, il, k);
      checks++;
      if (bus.in_ready !== m_ready()) begin
        failures++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", n, bus.in_ready, m_ready());
      end
      if (k) begin
        checks++;
        if (bus.ext_imm_src !== s) begin
          failures++; $display("FAIL rnd_src[%0d] ins=%h got=%0d exp=%0d", n, ins, bus.ext_imm_src, s);
        end
      end
      tick();
      checks++;
      if ({bus.out_valid, bus.stall_cnt} !== {m_valid, 4'(m_cnt)}) begin
        failures++; $display("FAIL rnd_state[%0d] got v=%b cnt=%0d exp v=%b cnt=%0d",
                             n, bus.out_valid, bus.stall_cnt, m_valid, m_cnt);
      end
      if (m_valid) begin
        checks++;
        if ({bus.out_instr, bus.out_pc, bus.out_imm, bus.out_has_imm, bus.out_illegal} !==
            {m_instr, m_pc, m_imm, m_has, m_ill}) begin
          failures++;
          $display("FAIL rnd_entry[%0d] got ins=%h pc=%h imm=%h has=%b ill=%b exp ins=%h pc=%h imm=%h has=%b ill=%b",
                   n, bus.out_instr, bus.out_pc, bus.out_imm, bus.out_has_imm, bus.out_illegal,
                   m_instr, m_pc, m_imm, m_has, m_ill);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    m_valid = 0; m_instr = 0; m_pc = 0; m_imm = 0; m_has = 0; m_ill = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
